pwm_cap: RTL and testbench
==========================

PWM_CAP -- requirements
Module: pwm_cap

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of period/high counters and results.
REQ-002 SHALL have parameter PSCR_WIDTH, default 20, width of prescaler divisor.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on pwm_i (min 2).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk_i and rst_i.
REQ-005 clk_i  in  1  sole clock; all flops rising-edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 en_i  in  1  capture enable; low forces IDLE.
REQ-008 pscr_i  in  PSCR_WIDTH  tick divisor; 0 treated as 1.
REQ-009 pwm_i  in  1  asynchronous PWM input.
REQ-010 period_o  out  CNT_WIDTH  ticks between consecutive rising edges.
REQ-011 high_o  out  CNT_WIDTH  ticks from rising edge to falling edge.
REQ-012 ovf_o  out  1  result saturated (counter hit all-ones).
REQ-013 valid_o  out  1  result register holds an unconsumed result.
REQ-014 ready_i  in  1  consumer accepts result when valid_o and ready_i are both high.
REQ-015 lost_o  out  1  sticky flag: a result was dropped.
REQ-016 irq_o  out  1  one-cycle pulse on each result load.

Function
REQ-017 pwm_i SHALL pass SYNC_STAGES flops; rise/fall SHALL be detected on the synced value versus a one-cycle-delayed copy.
REQ-018 The prescaler SHALL assert tick for one cycle every max(pscr_i,1) cycles; it clears when en_i is low or on a rising edge.
REQ-019 FSM states SHALL be IDLE, ARM, HIGH, LOW.
REQ-020 IDLE -> ARM when en_i=1; any state -> IDLE in the cycle after en_i=0; counters SHALL clear in IDLE.
REQ-021 ARM -> HIGH on rise; cnt <= 0; no result is produced, so the first partial period is discarded.
REQ-022 In HIGH/LOW, on tick, cnt SHALL increment and saturate at all-ones; saturation SHALL set the internal ovf bit.
REQ-023 HIGH -> LOW on fall; high capture SHALL equal cnt_q + tick, with the same saturation.
REQ-024 LOW -> HIGH on rise: period capture SHALL equal cnt_q + tick; the {period, high, ovf} result is offered; cnt <= 0; ovf bit clears.
REQ-025 A rise while in HIGH (fall missed, impossible after sync) SHALL be treated as in REQ-024 with high = period.
REQ-026 With pscr_i=1, a 10-cycle period at 30% duty SHALL yield period_o=10 and high_o=3.
REQ-027 Result load: if valid_o=0, or valid_o=1 and ready_i=1 in the same cycle, load the result, valid_o <= 1, and pulse irq_o the next cycle.
REQ-028 If valid_o=1 and ready_i=0 on a new result, the new result SHALL be dropped, the held result kept, and lost_o <= 1.
REQ-029 Accept without a new result SHALL set valid_o <= 0; the outputs SHALL hold their values until the next load.
REQ-030 lost_o SHALL clear only on rst_i or in IDLE; the result register and valid_o SHALL survive en_i=0 to allow drain.
REQ-031 A change of pscr_i mid-measurement SHALL take effect at the next tick boundary, and that result is not guaranteed.

Reset
REQ-032 On rst_i, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the synchronizer, counters, and prescaler SHALL be 0.
REQ-033 Reset mid-measurement SHALL discard the partial result, and the first result after reset SHALL follow REQ-021.

Structure
REQ-034 The FSM state typedef and the CNT/PSCR default widths SHALL live in shared package pwm_cap_pkg.
REQ-035 The synchronizer and edge detector SHALL be sub-module pwm_cap_edge (outputs: level, rise, fall).
REQ-036 The target size of pwm_cap plus pwm_cap_edge is 120-400 RTL lines.

Verification
REQ-037 pscr_i=1, pwm 10-cycle period, high 3 cycles, ready_i=1 -> the first result appears after the 2nd rise: period_o=10, high_o=3, ovf_o=0, one irq_o pulse per period.
REQ-038 pscr_i=4, pwm period 40, high 20 -> period_o=10 and high_o=5 (±1 on the first result only).
REQ-039 ready_i=0, three periods -> the first result is held, valid_o=1, lost_o=1 after the 2nd result; ready_i=1 then drains the held result, valid_o=0.
REQ-040 CNT_WIDTH=4, pscr_i=1, pwm period 40 -> period_o=15 (all-ones), ovf_o=1; the next normal 10-cycle period gives ovf_o=0.
REQ-041 en_i dropped mid-HIGH, then raised -> IDLE, lost_o=0, the held result is retained, and the first post-enable partial period produces no result.
REQ-042 rst_i pulsed while valid_o=1 -> all outputs 0 next cycle; capture restarts per REQ-021.

Source files
------------

// File: rtl/pwm_cap_pkg.sv
// Shared types and default widths for the PWM capture block.
package pwm_cap_pkg;

  localparam int CNT_WIDTH_DEF   = 32;
  localparam int PSCR_WIDTH_DEF  = 20;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_cap_edge.sv
// Synchronizes the asynchronous PWM input and flags its rising and falling edges.
module pwm_cap_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // synchronizer chain plus a one-cycle-delayed copy of the synced level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_i};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_cap.sv
// PWM period / high-time capture with prescaled tick, saturation and a
// single-entry result register with valid/ready handshake.
module pwm_cap
  import pwm_cap_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int PSCR_WIDTH  = PSCR_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic                  pwm_i,
  output logic [CNT_WIDTH-1:0]  period_o,
  output logic [CNT_WIDTH-1:0]  high_o,
  output logic                  ovf_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  lost_o,
  output logic                  irq_o
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [PSCR_WIDTH-1:0] PSCR_ONE = PSCR_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic b);
    if (a == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return a + {{(CNT_WIDTH-1){1'b0}}, b};
    end
  endfunction

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   high_q;
  logic                   ovf_q;
  logic [PSCR_WIDTH-1:0]  pcnt;
  logic [PSCR_WIDTH-1:0]  div;
  logic                   tick;
  logic                   level;
  logic                   rise;
  logic                   fall;
  logic [CNT_WIDTH-1:0]   cap;
  logic                   cap_full;
  logic                   new_res;
  logic [CNT_WIDTH-1:0]   res_period;
  logic [CNT_WIDTH-1:0]   res_high;
  logic                   res_ovf;

  pwm_cap_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pwm_i (pwm_i),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // >= rather than == so a divisor lowered mid-count still wraps at once
  assign div      = (pscr_i == '0) ? PSCR_ONE : pscr_i;
  assign tick     = (pcnt >= (div - PSCR_ONE));
  assign cap      = sat_add(cnt, tick);
  assign cap_full = (cap == CNT_MAX);

  // prescaler, realigned on every rising edge so each period starts fresh
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt <= '0;
    end else if (!en_i || rise || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PSCR_ONE;
    end
  end

  // a rise in HIGH or LOW closes a period; in HIGH the fall was missed
  always_comb begin
    new_res    = 1'b0;
    res_period = cap;
    res_high   = high_q;
    res_ovf    = ovf_q | cap_full;
    if (en_i && rise && level) begin
      case (state)
        HIGH: begin
          new_res  = 1'b1;
          res_high = cap;
        end
        LOW: begin
          new_res = 1'b1;
        end
        default: begin
          new_res = 1'b0;
        end
      endcase
    end else begin
      new_res = 1'b0;
    end
  end

  // capture FSM with its tick counter and the high-time snapshot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      high_q <= '0;
      ovf_q  <= 1'b0;
    end else if (!en_i) begin
      state  <= IDLE;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= ARM;
          cnt   <= '0;
          ovf_q <= 1'b0;
        end
        ARM: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= '0;
          end
        end
        HIGH: begin
          if (rise) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
          end else if (fall) begin
            state  <= LOW;
            high_q <= cap;
            cnt    <= cap;
            ovf_q  <= ovf_q | cap_full;
          end else begin
            cnt   <= cap;
            ovf_q <= ovf_q | cap_full;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= '0;
            ovf_q <= 1'b0;
          end else begin
            cnt   <= cap;
            ovf_q <= ovf_q | cap_full;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // result register: survives en_i low so a held result can still drain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_o <= '0;
      high_o   <= '0;
      ovf_o    <= 1'b0;
      valid_o  <= 1'b0;
      lost_o   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      irq_o <= 1'b0;
      if (new_res) begin
        if (!valid_o || ready_i) begin
          period_o <= res_period;
          high_o   <= res_high;
          ovf_o    <= res_ovf;
          valid_o  <= 1'b1;
          irq_o    <= 1'b1;
        end else begin
          lost_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (state == IDLE) begin
        lost_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_cap.sv
// Randomized and directed bench for pwm_cap: a 32-bit and a 4-bit instance
// share stimulus; results are predicted from period/duty arithmetic.
module tb_pwm_cap;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [19:0] pscr = 20'd1;
  logic        pwm = 1'b0;
  logic        ready = 1'b0;

  logic [31:0] m_period, m_high;
  logic        m_ovf, m_valid, m_lost, m_irq;
  logic [3:0]  s_period, s_high;
  logic        s_ovf, s_valid, s_lost, s_irq;

  int checks = 0;
  int errors = 0;

  res_t obs_m[$], obs_s[$], exp_m[$], exp_s[$];
  int   seg_h[$], seg_l[$];

  always #5 clk = ~clk;

  pwm_cap u_m (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pscr_i(pscr), .pwm_i(pwm),
    .period_o(m_period), .high_o(m_high), .ovf_o(m_ovf), .valid_o(m_valid),
    .ready_i(ready), .lost_o(m_lost), .irq_o(m_irq)
  );

  pwm_cap #(.CNT_WIDTH(4)) u_s (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pscr_i(pscr), .pwm_i(pwm),
    .period_o(s_period), .high_o(s_high), .ovf_o(s_ovf), .valid_o(s_valid),
    .ready_i(ready), .lost_o(s_lost), .irq_o(s_irq)
  );

  // one clock, then record any result announced by irq
  task automatic step();
    @(posedge clk);
    #1;
    if (m_irq) obs_m.push_back({m_period, m_high, m_ovf});
    if (s_irq) obs_s.push_back({28'd0, s_period, 28'd0, s_high, s_ovf});
  endtask

  // low l0, then each (high, low) segment, then one closing rise
  task automatic drive_train(input int l0);
    obs_m.delete();
    obs_s.delete();
    pwm = 1'b0;
    repeat (l0) step();
    foreach (seg_h[i]) begin
      pwm = 1'b1;
      repeat (seg_h[i]) step();
      pwm = 1'b0;
      repeat (seg_l[i]) step();
    end
    pwm = 1'b1;
    repeat (3) step();
    pwm = 1'b0;
    repeat (12) step();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // every full period yields floor(cycles/div) ticks, clipped at the counter max
  task automatic model(input int div);
    exp_m.delete();
    exp_s.delete();
    foreach (seg_h[i]) begin
      int p, h;
      p = (seg_h[i] + seg_l[i]) / div;
      h = seg_h[i] / div;
      exp_m.push_back({32'(p), 32'(h), 1'b0});
      exp_s.push_back({32'((p > 15) ? 15 : p), 32'((h > 15) ? 15 : h),
                       ((p >= 15) || (h >= 15)) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({m_period, m_high, m_ovf, m_valid, m_lost, m_irq} !== 70'd0) begin
      errors++;
      $display("FAIL reset_m got p=%0d h=%0d o=%b v=%b l=%b i=%b want all 0",
               m_period, m_high, m_ovf, m_valid, m_lost, m_irq);
    end
    checks++;
    if ({s_period, s_high, s_ovf, s_valid, s_lost, s_irq} !== 12'd0) begin
      errors++;
      $display("FAIL reset_s got p=%0d h=%0d o=%b v=%b l=%b i=%b want all 0",
               s_period, s_high, s_ovf, s_valid, s_lost, s_irq);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    pscr = 20'd1; ready = 1'b1; en = 1'b1;
    seg_h = '{3, 3, 3};
    seg_l = '{7, 7, 7};
    drive_train(6);
    checks++;
    if (obs_m.size() != 3) begin
      errors++;
      $display("FAIL basic_count got %0d want 3", obs_m.size());
    end
    foreach (obs_m[i]) begin
      checks++;
      if (obs_m[i] !== {32'd10, 32'd3, 1'b0}) begin
        errors++;
        $display("FAIL basic_res[%0d] got p=%0d h=%0d o=%b want 10/3/0",
                 i, obs_m[i].p, obs_m[i].h, obs_m[i].o);
      end
    end
    checks++;
    if ({m_valid, m_lost} !== 2'b00) begin
      errors++;
      $display("FAIL basic_drained got v=%b l=%b want 0 0", m_valid, m_lost);
    end
  endtask

  task automatic test_prescale();
    apply_reset();
    pscr = 20'd4; ready = 1'b1; en = 1'b1;
    seg_h = '{20, 20, 20};
    seg_l = '{20, 20, 20};
    drive_train(6);
    checks++;
    if (obs_m.size() != 3) begin
      errors++;
      $display("FAIL pscr_count got %0d want 3", obs_m.size());
    end
    foreach (obs_m[i]) begin
      int tol;
      tol = (i == 0) ? 1 : 0;
      checks++;
      if ((int'(obs_m[i].p) > 10 + tol) || (int'(obs_m[i].p) < 10 - tol) ||
          (int'(obs_m[i].h) > 5 + tol) || (int'(obs_m[i].h) < 5 - tol) || obs_m[i].o) begin
        errors++;
        $display("FAIL pscr_res[%0d] got p=%0d h=%0d o=%b want 10/5/0",
                 i, obs_m[i].p, obs_m[i].h, obs_m[i].o);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    pscr = 20'd1; ready = 1'b1; en = 1'b1;
    seg_h = '{3, 3};
    seg_l = '{37, 7};
    drive_train(6);
    checks++;
    if (obs_s.size() != 2) begin
      errors++;
      $display("FAIL sat_count got %0d want 2", obs_s.size());
    end else begin
      checks++;
      if (obs_s[0] !== {32'd15, 32'd3, 1'b1}) begin
        errors++;
        $display("FAIL sat_first got p=%0d h=%0d o=%b want 15/3/1",
                 obs_s[0].p, obs_s[0].h, obs_s[0].o);
      end
      checks++;
      if (obs_s[1] !== {32'd10, 32'd3, 1'b0}) begin
        errors++;
        $display("FAIL sat_next got p=%0d h=%0d o=%b want 10/3/0",
                 obs_s[1].p, obs_s[1].h, obs_s[1].o);
      end
    end
    checks++;
    if (obs_m.size() < 1 || obs_m[0] !== {32'd40, 32'd3, 1'b0}) begin
      errors++;
      $display("FAIL sat_wide got n=%0d want first 40/3/0", obs_m.size());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int d;
      apply_reset();
      pscr = 20'($urandom_range(0, 5));
      d = (pscr == 20'd0) ? 1 : int'(pscr);
      ready = 1'b1; en = 1'b1;
      seg_h.delete();
      seg_l.delete();
      for (int k = 0; k < 4; k++) begin
        seg_h.push_back(int'($urandom_range(2, 24)));
        seg_l.push_back(int'($urandom_range(2, 24)));
      end
      model(d);
      drive_train(6);
      checks++;
      if (obs_m.size() != exp_m.size() || obs_s.size() != exp_s.size()) begin
        errors++;
        $display("FAIL rand_count r=%0d got %0d/%0d want %0d",
                 r, obs_m.size(), obs_s.size(), exp_m.size());
      end else begin
        foreach (exp_m[i]) begin
          checks++;
          if (obs_m[i] !== exp_m[i]) begin
            errors++;
            $display("FAIL rand_m r=%0d i=%0d got %0d/%0d/%b want %0d/%0d/%b", r, i,
                     obs_m[i].p, obs_m[i].h, obs_m[i].o, exp_m[i].p, exp_m[i].h, exp_m[i].o);
          end
          checks++;
          if (obs_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL rand_s r=%0d i=%0d got %0d/%0d/%b want %0d/%0d/%b", r, i,
                     obs_s[i].p, obs_s[i].h, obs_s[i].o, exp_s[i].p, exp_s[i].h, exp_s[i].o);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    pscr = 20'd1; ready = 1'b0; en = 1'b1;
    seg_h = '{3, 4, 5};
    seg_l = '{7, 8, 9};
    drive_train(6);
    checks++;
    if (obs_m.size() != 1) begin
      errors++;
      $display("FAIL bp_irqs got %0d want 1", obs_m.size());
    end
    checks++;
    if ({m_valid, m_lost, m_period, m_high} !== {1'b1, 1'b1, 32'd10, 32'd3}) begin
      errors++;
      $display("FAIL bp_held got v=%b l=%b p=%0d h=%0d want 1 1 10 3",
               m_valid, m_lost, m_period, m_high);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if ({m_valid, m_period} !== {1'b0, 32'd10}) begin
      errors++;
      $display("FAIL bp_drain got v=%b p=%0d want 0 10", m_valid, m_period);
    end
  endtask

  task automatic test_disable();
    apply_reset();
    pscr = 20'd1; ready = 1'b0; en = 1'b1;
    seg_h = '{3, 4};
    seg_l = '{7, 8};
    drive_train(6);
    pwm = 1'b1;
    repeat (5) step();
    en = 1'b0;
    repeat (5) step();
    checks++;
    if ({m_lost, m_valid, m_period, m_high} !== {1'b0, 1'b1, 32'd10, 32'd3}) begin
      errors++;
      $display("FAIL dis_idle got l=%b v=%b p=%0d h=%0d want 0 1 10 3",
               m_lost, m_valid, m_period, m_high);
    end
    checks++;
    if (obs_m.size() != 1) begin
      errors++;
      $display("FAIL dis_irqs got %0d want 1", obs_m.size());
    end
    ready = 1'b1;
    step();
    en = 1'b1;
    seg_h = '{3};
    seg_l = '{7};
    drive_train(7);
    checks++;
    if (obs_m.size() != 1 || obs_m[0] !== {32'd10, 32'd3, 1'b0}) begin
      errors++;
      $display("FAIL dis_rearm got n=%0d want one 10/3/0", obs_m.size());
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; en = 1'b1;
    seg_h = '{3, 3};
    seg_l = '{7, 7};
    drive_train(6);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b want 1", m_valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({m_period, m_high, m_ovf, m_valid, m_lost, m_irq} !== 70'd0) begin
      errors++;
      $display("FAIL rstmid_out got p=%0d h=%0d v=%b l=%b want all 0",
               m_period, m_high, m_valid, m_lost);
    end
    rst = 1'b0;
    ready = 1'b1;
    seg_h = '{5, 2};
    seg_l = '{5, 8};
    drive_train(6);
    checks++;
    if (obs_m.size() != 2 || obs_m[0] !== {32'd10, 32'd5, 1'b0} ||
        obs_m[1] !== {32'd10, 32'd2, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_restart got n=%0d want 10/5/0 then 10/2/0", obs_m.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_saturate();
    test_random();
    test_backpressure();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
